// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types for the uart_tx arbiter: memory-port structs, arbiter state and slot layout.
package uart_tx_arbiter_pkg;

  typedef struct packed {
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
  } mem_in_type;

  typedef struct packed {
    logic [31:0] mem_rdata;
    logic        mem_error;
    logic        mem_ready;
  } mem_out_type;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} arb_state_type;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } arb_slot_type;

  localparam int DEFAULT_TIMEOUT = 1048576;

  // One spare bit so TIMEOUT-1 always fits even for power-of-two timeouts.
  function automatic int timer_width(input int timeout);
    return $clog2(timeout) + 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of req_mask searching upward from last_grant+1.
module rr_pick #(
  parameter int NREQ = 2,
  parameter int IDXW = 1
) (
  input  logic [NREQ-1:0] req_mask,
  input  logic [IDXW-1:0] last_grant,
  output logic [IDXW-1:0] grant,
  output logic            any
);

  logic [IDXW-1:0] idx;

  // Walk the offsets from farthest to nearest so the nearest valid slot is assigned last.
  always_comb begin
    grant = '0;
    any   = 1'b0;
    idx   = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = IDXW'((int'(last_grant) + k) % NREQ);
      if (req_mask[idx]) begin
        grant = idx;
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx memory port among NREQ requesters, with timeout.
//   state | meaning
//   IDLE  | waiting for a valid slot; picks the next grant round-robin
//   ISSUE | tx_mem_in carries the granted slot with mem_valid=1 for this cycle
//   WAIT  | waiting for uart_tx mem_ready or the timeout
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                    clock,
  input  logic                    reset,
  input  mem_in_type  [NREQ-1:0]  req_in,
  output mem_out_type [NREQ-1:0]  req_out,
  output mem_in_type              tx_mem_in,
  input  mem_out_type             tx_mem_out,
  output logic        [NREQ-1:0]  overflow,
  output logic                    busy
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW   = timer_width(TIMEOUT);

  typedef struct packed {
    arb_state_type                state;
    logic [IDXW-1:0]              grant;
    logic [IDXW-1:0]              last_grant;
    logic [TW-1:0]                timer;
    arb_slot_type [NREQ-1:0]      slot;
    mem_out_type  [NREQ-1:0]      req_out;
    mem_in_type                   tx_mem_in;
    logic [NREQ-1:0]              overflow;
    logic                         busy;
  } register_type;

  register_type    r_q, r_d;
  arb_state_type   state_d;
  logic [NREQ-1:0] slot_mask;
  logic            resp_pending;
  logic [IDXW-1:0] pick_grant;
  logic            pick_any;
  logic            timer_done;

  rr_pick #(.NREQ(NREQ), .IDXW(IDXW)) u_rr_pick (
    .req_mask   (slot_mask),
    .last_grant (r_q.last_grant),
    .grant      (pick_grant),
    .any        (pick_any)
  );

  assign timer_done = (r_q.timer == TW'(TIMEOUT - 1));

  always_comb begin
    slot_mask    = '0;
    resp_pending = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      slot_mask[i] = r_q.slot[i].valid;
      resp_pending = resp_pending | r_q.req_out[i].mem_ready;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_q            <= '0;
      r_q.last_grant <= IDXW'(NREQ - 1);
    end else begin
      r_q <= r_d;
    end
  end

  // IDLE holds off during the response cycle so the next issue lands at least k+3.
  always_comb begin
    state_d = r_q.state;
    unique case (r_q.state)
      IDLE:    if (pick_any && !resp_pending) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (tx_mem_out.mem_ready || timer_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    r_d           = r_q;
    r_d.state     = state_d;
    r_d.req_out   = '0;
    r_d.tx_mem_in = '0;
    r_d.overflow  = '0;

    for (int i = 0; i < NREQ; i++) begin
      if (req_in[i].mem_valid) begin
        if (r_q.slot[i].valid) begin
          r_d.overflow[i] = 1'b1;
        end else begin
          r_d.slot[i].valid = 1'b1;
          r_d.slot[i].addr  = req_in[i].mem_addr;
          r_d.slot[i].wdata = req_in[i].mem_wdata;
          r_d.slot[i].wstrb = req_in[i].mem_wstrb;
        end
      end
    end

    unique case (r_q.state)
      IDLE: begin
        if (state_d == ISSUE) begin
          r_d.grant               = pick_grant;
          r_d.tx_mem_in.mem_valid = 1'b1;
          r_d.tx_mem_in.mem_addr  = r_q.slot[pick_grant].addr;
          r_d.tx_mem_in.mem_wdata = r_q.slot[pick_grant].wdata;
          r_d.tx_mem_in.mem_wstrb = r_q.slot[pick_grant].wstrb;
        end
      end
      ISSUE: r_d.timer = '0;
      WAIT: begin
        r_d.timer = r_q.timer + TW'(1);
        if (state_d == IDLE) begin
          r_d.req_out[r_q.grant].mem_ready = 1'b1;
          if (tx_mem_out.mem_ready) begin
            r_d.req_out[r_q.grant].mem_rdata = tx_mem_out.mem_rdata;
            r_d.req_out[r_q.grant].mem_error = tx_mem_out.mem_error;
          end else begin
            r_d.req_out[r_q.grant].mem_error = 1'b1;
          end
          r_d.slot[r_q.grant] = '0;
          r_d.last_grant      = r_q.grant;
        end
      end
      default: ;
    endcase

    r_d.busy = (state_d != IDLE);
    for (int i = 0; i < NREQ; i++) begin
      r_d.busy = r_d.busy | r_d.slot[i].valid;
    end
  end

  assign req_out   = r_q.req_out;
  assign tx_mem_in = r_q.tx_mem_in;
  assign overflow  = r_q.overflow;
  assign busy      = r_q.busy;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: vector table for single transactions plus multi-cycle sequences.
module tb_uart_tx_arbiter;
  import uart_tx_arbiter_pkg::*;

  logic                   clock;
  logic                   rst_n;
  mem_in_type  [1:0]      req_in;
  mem_out_type [1:0]      req_out;
  mem_in_type             tx_mem_in;
  mem_out_type            tx_mem_out;
  logic        [1:0]      overflow;
  logic                   busy;

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;

  logic        stub_ready = 1'b0;
  int          stub_cnt   = 0;
  logic [31:0] stub_addr  = 32'h0;

  typedef struct { int cyc; logic [7:0] b; } tx_ev_t;
  typedef struct { int cyc; int port; logic err; logic [31:0] rdata; } resp_ev_t;
  typedef struct { int cyc; logic [1:0] mask; } ovf_ev_t;

  tx_ev_t   tx_q[$];
  resp_ev_t resp_q[$];
  ovf_ev_t  ovf_q[$];

  typedef struct {
    int          port;
    logic [31:0] addr;
    logic [7:0]  wdata;
    logic [3:0]  wstrb;
    int          tx_off;
    int          resp_off;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs[4];

  uart_tx_arbiter #(.NREQ(2), .TIMEOUT(16)) dut (
    .clock      (clock),
    .reset      (rst_n),
    .req_in     (req_in),
    .req_out    (req_out),
    .tx_mem_in  (tx_mem_in),
    .tx_mem_out (tx_mem_out),
    .overflow   (overflow),
    .busy       (busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  // Downstream stub: acknowledges writes 5 cycles after mem_valid, never acknowledges reads.
  always @(posedge clock) begin
    stub_ready <= 1'b0;
    if (tx_mem_in.mem_valid && tx_mem_in.mem_wstrb != 4'h0) begin
      stub_cnt  <= 4;
      stub_addr <= tx_mem_in.mem_addr;
    end else if (stub_cnt > 1) begin
      stub_cnt <= stub_cnt - 1;
    end else if (stub_cnt == 1) begin
      stub_cnt   <= 0;
      stub_ready <= 1'b1;
    end
  end

  assign tx_mem_out = '{mem_rdata: stub_ready ? (32'h1234_0000 | stub_addr) : 32'h0,
                        mem_error: 1'b0,
                        mem_ready: stub_ready};

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (tx_mem_in.mem_valid) tx_q.push_back('{cyc, tx_mem_in.mem_wdata[7:0]});
    for (int i = 0; i < 2; i++) begin
      if (req_out[i].mem_ready)
        resp_q.push_back('{cyc, i, req_out[i].mem_error, req_out[i].mem_rdata});
      else
        chk($sformatf("idle_resp_zero_p%0d", i), 128'({req_out[i].mem_rdata, req_out[i].mem_error}), 128'(0));
    end
    if (overflow != 2'b00) ovf_q.push_back('{cyc, overflow});
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input int p, input logic [31:0] a, input logic [7:0] d, input logic [3:0] s);
    req_in[p].mem_valid = 1'b1;
    req_in[p].mem_addr  = a;
    req_in[p].mem_wdata = {24'h0, d};
    req_in[p].mem_wstrb = s;
  endtask

  task automatic wait_resp(input int want, input int budget);
    int n;
    n = 0;
    while (resp_q.size() < want && n < budget) begin
      tick();
      n++;
    end
    chk("resp_wait", 128'(resp_q.size()), 128'(want));
  endtask

  task automatic clear_logs();
    tx_q.delete();
    resp_q.delete();
    ovf_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, total=%0d", total);
    $fatal(1, "watchdog");
  end

  initial begin
    int  t0;
    logic reposted;
    int  n;

    vecs[0] = '{0, 32'h0, 8'h41, 4'h1, 2, 8,  1'b0, 32'h1234_0000};
    vecs[1] = '{1, 32'h0, 8'h42, 4'h1, 2, 8,  1'b0, 32'h1234_0000};
    vecs[2] = '{0, 32'h8, 8'h00, 4'h0, 2, 19, 1'b1, 32'h0};
    vecs[3] = '{1, 32'h4, 8'h7E, 4'h1, 2, 8,  1'b0, 32'h1234_0004};

    rst_n  = 1'b0;
    req_in = '0;
    repeat (3) tick();
    chk("rst_req_out",   128'(req_out),   128'(0));
    chk("rst_tx_mem_in", 128'(tx_mem_in), 128'(0));
    chk("rst_overflow",  128'(overflow),  128'(0));
    chk("rst_busy",      128'(busy),      128'(0));
    rst_n = 1'b1;
    repeat (2) tick();

    for (int v = 0; v < 4; v++) begin
      clear_logs();
      drive(vecs[v].port, vecs[v].addr, vecs[v].wdata, vecs[v].wstrb);
      t0 = cyc;
      tick();
      req_in = '0;
      wait_resp(1, 40);
      repeat (2) tick();
      chk($sformatf("v%0d_tx_count", v), 128'(tx_q.size()), 128'(1));
      if (tx_q.size() > 0) begin
        chk($sformatf("v%0d_tx_off", v),  128'(tx_q[0].cyc - t0), 128'(vecs[v].tx_off));
        chk($sformatf("v%0d_tx_byte", v), 128'(tx_q[0].b),        128'(vecs[v].wdata));
      end
      if (resp_q.size() > 0) begin
        chk($sformatf("v%0d_resp_port", v),  128'(resp_q[0].port),       128'(vecs[v].port));
        chk($sformatf("v%0d_resp_off", v),   128'(resp_q[0].cyc - t0),   128'(vecs[v].resp_off));
        chk($sformatf("v%0d_resp_err", v),   128'(resp_q[0].err),        128'(vecs[v].err));
        chk($sformatf("v%0d_resp_rdata", v), 128'(resp_q[0].rdata),      128'(vecs[v].rdata));
      end
    end

    // Both ports at once, port 0 re-posts in its response cycle.
    clear_logs();
    drive(0, 32'h0, 8'h41, 4'h1);
    drive(1, 32'h0, 8'h42, 4'h1);
    t0 = cyc;
    tick();
    req_in = '0;
    chk("rr_busy_high", 128'(busy), 128'(1));
    reposted = 1'b0;
    n = 0;
    while (resp_q.size() < 3 && n < 80) begin
      tick();
      n++;
      if (!reposted && req_out[0].mem_ready) begin
        drive(0, 32'h0, 8'h43, 4'h1);
        reposted = 1'b1;
        tick();
        n++;
        req_in = '0;
      end
    end
    chk("rr_resp_count", 128'(resp_q.size()), 128'(3));
    chk("rr_tx_count",   128'(tx_q.size()),   128'(3));
    if (tx_q.size() == 3) begin
      chk("rr_tx0", 128'(tx_q[0].b), 128'(8'h41));
      chk("rr_tx1", 128'(tx_q[1].b), 128'(8'h42));
      chk("rr_tx2", 128'(tx_q[2].b), 128'(8'h43));
      chk("rr_tx1_gap", 128'(tx_q[1].cyc - t0), 128'(10));
    end
    if (resp_q.size() == 3) begin
      chk("rr_resp0_port", 128'(resp_q[0].port), 128'(0));
      chk("rr_resp1_port", 128'(resp_q[1].port), 128'(1));
      chk("rr_resp2_port", 128'(resp_q[2].port), 128'(0));
    end
    repeat (3) tick();
    chk("rr_busy_low", 128'(busy), 128'(0));

    // Overflow while pending, and a request in the completion cycle.
    clear_logs();
    drive(1, 32'h0, 8'h50, 4'h1);
    t0 = cyc;
    tick();
    req_in = '0;
    repeat (2) tick();
    drive(1, 32'h0, 8'h51, 4'h1);
    tick();
    req_in = '0;
    repeat (3) tick();
    drive(1, 32'h0, 8'h52, 4'h1);
    tick();
    req_in = '0;
    wait_resp(1, 30);
    repeat (10) tick();
    chk("ovf_count", 128'(ovf_q.size()), 128'(2));
    if (ovf_q.size() == 2) begin
      chk("ovf0_cyc",  128'(ovf_q[0].cyc - t0), 128'(4));
      chk("ovf0_mask", 128'(ovf_q[0].mask),     128'(2'b10));
      chk("ovf1_cyc",  128'(ovf_q[1].cyc - t0), 128'(8));
      chk("ovf1_mask", 128'(ovf_q[1].mask),     128'(2'b10));
    end
    chk("ovf_tx_count",   128'(tx_q.size()),   128'(1));
    chk("ovf_resp_count", 128'(resp_q.size()), 128'(1));
    if (tx_q.size() > 0) chk("ovf_tx_byte", 128'(tx_q[0].b), 128'(8'h50));

    // Timeout on a read, then the other pending slot is granted.
    clear_logs();
    drive(0, 32'h8, 8'h00, 4'h0);
    t0 = cyc;
    tick();
    req_in = '0;
    drive(1, 32'h0, 8'h60, 4'h1);
    tick();
    req_in = '0;
    wait_resp(2, 60);
    if (resp_q.size() == 2) begin
      chk("to_resp0_port", 128'(resp_q[0].port),     128'(0));
      chk("to_resp0_off",  128'(resp_q[0].cyc - t0), 128'(19));
      chk("to_resp0_err",  128'(resp_q[0].err),      128'(1));
      chk("to_resp1_port", 128'(resp_q[1].port),     128'(1));
      chk("to_resp1_err",  128'(resp_q[1].err),      128'(0));
    end
    if (tx_q.size() == 2) begin
      chk("to_tx1_byte", 128'(tx_q[1].b),        128'(8'h60));
      chk("to_tx1_off",  128'(tx_q[1].cyc - t0), 128'(21));
    end
    repeat (2) tick();

    // Port 0 served last, so before reset port 1 would be preferred.
    clear_logs();
    drive(0, 32'h0, 8'h6A, 4'h1);
    tick();
    req_in = '0;
    wait_resp(1, 30);
    repeat (2) tick();

    // Reset while port 1 is in WAIT and port 0 is pending.
    clear_logs();
    drive(0, 32'h0, 8'h70, 4'h1);
    drive(1, 32'h0, 8'h71, 4'h1);
    tick();
    req_in = '0;
    repeat (3) tick();
    if (tx_q.size() > 0) chk("rst_inflight_byte", 128'(tx_q[0].b), 128'(8'h71));
    rst_n = 1'b0;
    #1;
    chk("midrst_req_out",   128'(req_out),   128'(0));
    chk("midrst_tx_mem_in", 128'(tx_mem_in), 128'(0));
    chk("midrst_overflow",  128'(overflow),  128'(0));
    chk("midrst_busy",      128'(busy),      128'(0));
    tick();
    rst_n = 1'b1;
    clear_logs();
    repeat (6) tick();
    chk("stray_resp_count", 128'(resp_q.size()), 128'(0));
    chk("stray_tx_count",   128'(tx_q.size()),   128'(0));
    chk("stray_busy",       128'(busy),          128'(0));
    drive(0, 32'h0, 8'h80, 4'h1);
    drive(1, 32'h0, 8'h81, 4'h1);
    tick();
    req_in = '0;
    wait_resp(2, 60);
    if (tx_q.size() == 2) begin
      chk("post_rst_tx0", 128'(tx_q[0].b), 128'(8'h80));
      chk("post_rst_tx1", 128'(tx_q[1].b), 128'(8'h81));
    end
    if (resp_q.size() == 2) chk("post_rst_first_port", 128'(resp_q[0].port), 128'(0));
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one uart_tx memory port among NREQ requesters, for example several harts or a debug unit. Each requester issues single-cycle mem_valid pulses. The block latches each request into a per-requester slot and grants slots round-robin. It forwards exactly one transaction at a time to uart_tx and waits for its mem_ready before granting the next. A timeout returns mem_error for accesses that uart_tx never acknowledges, such as reads.

Parameters:
NREQ, 2, number of requester ports (2..8)
TIMEOUT, 1048576, cycles in WAIT before aborting a transaction with error (must exceed 11*clock_rate of uart_tx)

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-low reset
req_in  input  mem_in_type[NREQ]  requester requests (mem_valid, mem_addr, mem_wdata, mem_wstrb)
req_out  output  mem_out_type[NREQ]  requester responses (mem_rdata, mem_error, mem_ready)
tx_mem_in  output  mem_in_type  request to uart_tx (drives its uart_in)
tx_mem_out  input  mem_out_type  response from uart_tx (its uart_out)
overflow  output  NREQ  one-cycle pulse: request dropped because the slot was occupied
busy  output  1  high whenever state != IDLE or any slot is valid

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: all req_out fields 0, tx_mem_in all fields 0, overflow 0, busy 0, all slots empty, state IDLE, last_grant = NREQ-1 so requester 0 wins first.
- Registered outputs: every output is registered. There is no combinational path from input to output.
- Slot capture: req_in[i].mem_valid=1 with slot i empty → at that edge slot i stores {addr, wdata, wstrb} and is marked valid.
  - Slot i already valid → request dropped, slot unchanged, overflow[i]=1 on the next cycle.
  - A request arriving in the same cycle the slot's completion is detected still sees the slot full and is dropped. Requesters must wait for mem_ready.
- FSM, three states:
  - IDLE: if any slot is valid, pick g = first valid index searching from last_grant+1 modulo NREQ, register grant=g, go to ISSUE.
  - ISSUE: tx_mem_in = slot g fields with mem_valid=1 for exactly one cycle, timer cleared, go to WAIT.
  - WAIT: tx_mem_in.mem_valid=0 and the timer increments each cycle.
    - If tx_mem_out.mem_ready=1: next cycle req_out[g] = {mem_ready=1, mem_rdata=tx_mem_out.mem_rdata, mem_error=tx_mem_out.mem_error}; slot g cleared; last_grant=g; go to IDLE.
    - Else if timer==TIMEOUT-1: next cycle req_out[g] = {mem_ready=1, mem_error=1, mem_rdata=0}; slot g cleared; last_grant=g; go to IDLE.
- Response pulses: req_out[i].mem_ready is a single-cycle pulse. rdata and error are 0 whenever mem_ready=0.
- Latency: request pulse in cycle 0 → slot valid in cycle 1 (IDLE selects) → tx_mem_in.mem_valid=1 in cycle 2. tx_mem_out.mem_ready in cycle k → req_out mem_ready in cycle k+1 → next grant's mem_valid no earlier than cycle k+3.
- Ignored ready: tx_mem_out.mem_ready outside WAIT is ignored, including stray pulses after reset from an in-flight uart_tx transmission.
- Fairness: a requester re-posting immediately after its response cannot win over another valid slot.
- Timer width: clog2(TIMEOUT)+1 bits; no wrap because the timer is cleared in ISSUE.
- Reset mid-transaction: slots are discarded with no response generated. uart_tx may still be shifting, so a write issued immediately after reset may be dropped by uart_tx; that write returns via timeout.

Decomposition:
- Package (wires/configure side): arb_state_type enum {IDLE, ISSUE, WAIT}; arb_slot_type packed struct {valid, addr, wdata, wstrb}; TIMEOUT width localparam.
- Sub-module rr_pick: combinational round-robin picker with inputs req_mask[NREQ] and last_grant, outputs grant index and any.
- All other logic lives in one r/rin register_type, following the uart_tx structure.

Test Plan:
- NREQ=2, stub downstream returns ready 5 cycles after valid; req0 writes 0x41 in cycle 0 → tx_mem_in.mem_valid in cycle 2 with wdata[7:0]=0x41, req_out[0].mem_ready in cycle 8, error 0.
- req0 and req1 both pulse in cycle 0 (0x41, 0x42) → tx sees 0x41 then 0x42; each gets exactly one ready pulse. req0 re-posts 0x43 on its response → order is 0x41, 0x42, 0x43.
- req1 pulses again while its slot is pending → overflow[1]=1 one cycle later; original byte still delivered once; dropped byte never appears on tx_mem_in.
- TIMEOUT=16, stub never answers (read, addr 8, wstrb 0) → req_out[0].mem_ready=1 with mem_error=1 exactly 16 cycles after the WAIT entry; next pending slot granted afterward.
- Reset asserted in WAIT with a slot pending in the other port → all outputs 0 immediately; after release a stray stub ready is ignored; the first new request goes to port 0.
- Real uart_tx with clock_rate=4 and HARDWARE=1: three requesters send 0x55, 0xAA, 0x0F → tx line shows three complete 10-bit frames, no truncation, round-robin order.
